// File: rtl/wfifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port between four wclk-domain
// requesters; each written word carries its source ID in the top two bits.

module wfifo_wr_arbiter_lane (
    input  logic sel,
    input  logic full,
    input  logic valid,
    output logic ready,
    output logic xfer
);
    // ready depends only on grant and full, never on the requester's data
    assign ready = sel & ~full;
    assign xfer  = ready & valid;
endmodule

module wfifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                    wclk,
    input  logic                    rst_n,
    input  logic [3:0]              req_valid,
    input  logic [3:0]              req_last,
    input  logic [4*DATA_WIDTH-1:0] req_data,
    output logic [3:0]              req_ready,
    input  logic                    full,
    output logic                    winc,
    output logic [DATA_WIDTH+1:0]   wdata,
    output logic [1:0]              grant_id,
    output logic                    busy
);
    localparam int NUM_REQ = 4;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                             state, state_nxt;
    logic   [1:0]                       last_ptr;
    logic   [3:0]                       beat_cnt;
    logic   [1:0]                       pick_idx;
    logic   [1:0]                       scan_idx;
    logic                               any_valid;
    logic                               g_valid;
    logic                               g_last;
    logic                               xfer;
    logic                               release_g;
    logic   [NUM_REQ-1:0]               lane_xfer;
    logic   [NUM_REQ-1:0][DATA_WIDTH-1:0] data_arr;

    assign data_arr  = req_data;
    assign busy      = (state == GRANT);
    assign any_valid = |req_valid;
    assign g_valid   = req_valid[grant_id];
    assign g_last    = req_last[grant_id];

    genvar i;
    generate
        for (i = 0; i < NUM_REQ; i++) begin : g_lane
            wfifo_wr_arbiter_lane u_lane (
                .sel   (busy && (grant_id == 2'(i))),
                .full  (full),
                .valid (req_valid[i]),
                .ready (req_ready[i]),
                .xfer  (lane_xfer[i])
            );
        end
    endgenerate

    assign xfer  = |lane_xfer;
    assign winc  = xfer;
    assign wdata = busy ? {grant_id, data_arr[grant_id]} : '0;

    // Descending scan so the index nearest after last_ptr overrides the others
    always_comb begin
        pick_idx = last_ptr;
        scan_idx = last_ptr;
        for (int k = NUM_REQ; k >= 1; k--) begin
            scan_idx = last_ptr + 2'(k);
            if (req_valid[scan_idx]) pick_idx = scan_idx;
        end
    end

    // Withdrawal releases even while full holds off the transfer
    assign release_g = ~g_valid |
                       (xfer & (g_last | (beat_cnt == 4'(MAX_BURST - 1))));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_valid) state_nxt = GRANT;
            GRANT:   if (release_g) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant_id <= 2'd0;
            last_ptr <= 2'd3;
            beat_cnt <= 4'd0;
        end else begin
            state <= state_nxt;
            if (state == IDLE) begin
                if (any_valid) begin
                    grant_id <= pick_idx;
                    beat_cnt <= 4'd0;
                end
            end else if (release_g) begin
                last_ptr <= grant_id;
                beat_cnt <= 4'd0;
            end else if (xfer) begin
                beat_cnt <= beat_cnt + 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_wfifo_wr_arbiter.sv
// Directed-vector bench for wfifo_wr_arbiter: table of per-cycle inputs and
// expected outputs, plus hand-written withdrawal and mid-burst reset sequences.

module tb_wfifo_wr_arbiter;
    logic        wclk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_last;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        full;
    logic        winc;
    logic [9:0]  wdata;
    logic [1:0]  grant_id;
    logic        busy;

    int n_vec;
    int n_bad;

    wfifo_wr_arbiter #(.DATA_WIDTH(8), .MAX_BURST(4)) dut (
        .wclk      (wclk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_data  (req_data),
        .req_ready (req_ready),
        .full      (full),
        .winc      (winc),
        .wdata     (wdata),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    // exp = {req_ready, winc, wdata, grant_id, busy}
    typedef struct {
        logic        rst;
        logic [3:0]  valid;
        logic [3:0]  last;
        logic [31:0] data;
        logic        full;
        logic [17:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic e(input logic r, input logic [3:0] v, input logic [3:0] l,
                     input logic [31:0] d, input logic f, input logic [3:0] rdy,
                     input logic wi, input logic [9:0] wd, input logic [1:0] g,
                     input logic b);
        vec_t t;
        t.rst = r; t.valid = v; t.last = l; t.data = d; t.full = f;
        t.exp = {rdy, wi, wd, g, b};
        tbl.push_back(t);
    endtask

    task automatic check(input string name, input logic [17:0] got, input logic [17:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [3:0] v, input logic [3:0] l,
                         input logic [31:0] d, input logic f);
        @(negedge wclk);
        rst_n = r; req_valid = v; req_last = l; req_data = d; full = f;
        #1;
    endtask

    function automatic logic [17:0] outs();
        return {req_ready, winc, wdata, grant_id, busy};
    endfunction

    initial begin
        logic [31:0] d;
        int writes;
        int cyc;
        n_vec = 0; n_bad = 0;
        rst_n = 1'b0; req_valid = '0; req_last = '0; req_data = '0; full = 1'b0;

        // single beat after reset
        e(0, 4'h1, 4'h1, 32'hA5, 0, 4'h0, 0, 10'h000, 2'd0, 0);
        e(1, 4'h1, 4'h1, 32'hA5, 0, 4'h0, 0, 10'h000, 2'd0, 0);
        e(1, 4'h1, 4'h1, 32'hA5, 0, 4'h1, 1, 10'h0A5, 2'd0, 1);
        e(1, 4'h0, 4'h0, 32'hA5, 0, 4'h0, 0, 10'h000, 2'd0, 0);
        // round-robin, all valid, single-beat bursts
        d = 32'h13121110;
        e(0, 4'h0, 4'h0, d, 0, 4'h0, 0, 10'h000, 2'd0, 0);
        e(1, 4'hF, 4'hF, d, 0, 4'h0, 0, 10'h000, 2'd0, 0);
        e(1, 4'hF, 4'hF, d, 0, 4'h1, 1, 10'h010, 2'd0, 1);
        e(1, 4'hF, 4'hF, d, 0, 4'h0, 0, 10'h000, 2'd0, 0);
        e(1, 4'hF, 4'hF, d, 0, 4'h2, 1, 10'h111, 2'd1, 1);
        e(1, 4'hF, 4'hF, d, 0, 4'h0, 0, 10'h000, 2'd1, 0);
        e(1, 4'hF, 4'hF, d, 0, 4'h4, 1, 10'h212, 2'd2, 1);
        e(1, 4'hF, 4'hF, d, 0, 4'h0, 0, 10'h000, 2'd2, 0);
        e(1, 4'hF, 4'hF, d, 0, 4'h8, 1, 10'h313, 2'd3, 1);
        e(1, 4'hF, 4'hF, d, 0, 4'h0, 0, 10'h000, 2'd3, 0);
        e(1, 4'hF, 4'hF, d, 0, 4'h1, 1, 10'h010, 2'd0, 1);
        e(1, 4'h0, 4'h0, d, 0, 4'h0, 0, 10'h000, 2'd0, 0);
        // forced split on req 2, req 1 interleaves, req 3 skipped
        d = 32'h00221100;
        e(0, 4'h0, 4'h0, d, 0, 4'h0, 0, 10'h000, 2'd0, 0);
        e(1, 4'h4, 4'h0, d, 0, 4'h0, 0, 10'h000, 2'd0, 0);
        for (int k = 0; k < 4; k++) e(1, 4'h6, 4'h0, d, 0, 4'h4, 1, 10'h222, 2'd2, 1);
        e(1, 4'h6, 4'h2, d, 0, 4'h0, 0, 10'h000, 2'd2, 0);
        e(1, 4'h6, 4'h2, d, 0, 4'h2, 1, 10'h111, 2'd1, 1);
        e(1, 4'h4, 4'h0, d, 0, 4'h0, 0, 10'h000, 2'd1, 0);
        e(1, 4'h4, 4'h0, d, 0, 4'h4, 1, 10'h222, 2'd2, 1);
        e(1, 4'h0, 4'h0, d, 0, 4'h4, 0, 10'h222, 2'd2, 1);
        e(1, 4'h0, 4'h0, d, 0, 4'h0, 0, 10'h000, 2'd2, 0);
        // backpressure in the middle of a 3-beat burst
        e(0, 4'h0, 4'h0, 32'h30, 0, 4'h0, 0, 10'h000, 2'd0, 0);
        e(1, 4'h1, 4'h0, 32'h30, 0, 4'h0, 0, 10'h000, 2'd0, 0);
        e(1, 4'h1, 4'h0, 32'h30, 0, 4'h1, 1, 10'h030, 2'd0, 1);
        for (int k = 0; k < 3; k++) e(1, 4'h1, 4'h0, 32'h31, 1, 4'h0, 0, 10'h031, 2'd0, 1);
        e(1, 4'h1, 4'h0, 32'h31, 0, 4'h1, 1, 10'h031, 2'd0, 1);
        e(1, 4'h1, 4'h1, 32'h32, 0, 4'h1, 1, 10'h032, 2'd0, 1);
        e(1, 4'h0, 4'h0, 32'h32, 0, 4'h0, 0, 10'h000, 2'd0, 0);

        foreach (tbl[n]) begin
            drive(tbl[n].rst, tbl[n].valid, tbl[n].last, tbl[n].data, tbl[n].full);
            check($sformatf("vec%0d", n), outs(), tbl[n].exp);
        end

        // withdrawal: req 1 drops after 2 beats, req 3 next in line
        drive(0, 4'h0, 4'h0, 32'h0, 0);
        drive(1, 4'h2, 4'h0, 32'h00004100, 0);
        writes = 0;
        cyc = 0;
        do begin
            drive(1, (writes >= 2) ? 4'h8 : 4'h2, 4'h0, 32'h00004100 + 32'(writes << 8), 0);
            if (winc) writes++;
            cyc++;
        end while (busy && cyc < 20);
        check("wd_writes", 18'(writes), 18'd2);
        check("wd_release", {16'h0, busy, winc}, 18'h0);
        drive(1, 4'h8, 4'h0, 32'h0, 0);
        drive(1, 4'h8, 4'h0, 32'h0, 0);
        check("wd_next", {grant_id, busy}, {2'd3, 1'b1});

        // reset mid-burst on req 1
        drive(0, 4'h0, 4'h0, 32'h0, 0);
        drive(1, 4'h2, 4'h0, 32'h00005100, 0);
        drive(1, 4'h2, 4'h0, 32'h00005100, 0);
        drive(1, 4'h2, 4'h0, 32'h00005200, 0);
        check("rm_beat2", outs(), {4'h2, 1'b1, 10'h152, 2'd1, 1'b1});
        rst_n = 1'b0;
        #1;
        check("rm_async", outs(), 18'h0);
        drive(1, 4'h3, 4'h0, 32'h00005100, 0);
        check("rm_idle", outs(), 18'h0);
        drive(1, 4'h3, 4'h0, 32'h00005160, 0);
        check("rm_prio0", outs(), {4'h1, 1'b1, 10'h060, 2'd0, 1'b1});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/wfifo_wr_arbiter.md
Name: wfifo_wr_arbiter

Overview:
- Shares the single write port of the async FIFO between four requesters in the wclk domain.
- Grants are round-robin. Each grant covers a burst that ends on last, on MAX_BURST beats, or when the requester withdraws.
- Drives winc/wdata into the FIFO write side and honours its registered full flag.
- Each word is tagged with the source ID so the read side can demultiplex.

Parameters:
- DATA_WIDTH, 8, payload width per requester.
- MAX_BURST, 4, maximum beats per grant (1..15; 4-bit beat counter).

Ports:
- wclk  input  1  write-domain clock
- rst_n  input  1  reset
- req_valid  input  4  per-requester word valid
- req_last  input  4  per-requester end-of-burst marker, qualified by valid
- req_data  input  4*DATA_WIDTH  requester i data at bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  output  4  per-requester accept, combinational
- full  input  1  FIFO full flag, registered in wclk domain
- winc  output  1  FIFO write enable, combinational
- wdata  output  DATA_WIDTH+2  {src_id[1:0], payload}, combinational
- grant_id  output  2  index of current/last granted requester, registered
- busy  output  1  1 while in GRANT state, registered

Behaviour:
- Reset is asynchronous, active-low (rst_n); clock is wclk.
- Values in reset:
  - state=IDLE, busy=0, grant_id=0, beat_cnt=0.
  - RR pointer last=3, so requester 0 has first priority.
  - req_ready=0, winc=0.
- State machine has two states, IDLE and GRANT.
- IDLE:
  - req_ready=0, winc=0.
  - If any req_valid: select the first valid index scanning last+1, last+2, ... mod 4.
  - Register grant_id=that index, beat_cnt=0, busy=1, go to GRANT. Arbitration latency is 1 cycle.
  - If no valid: stay in IDLE.
- GRANT, with g=grant_id:
  - req_ready[g] = ~full; all other ready bits are 0.
  - Transfer xfer = req_valid[g] & ~full.
  - winc = xfer. wdata = {g, req_data[g]} whenever busy; wdata=0 in IDLE.
  - On xfer: beat_cnt++.
- GRANT release goes to IDLE with last=g, busy=0, beat_cnt=0. Release triggers:
  - (a) xfer & req_last[g];
  - (b) xfer & beat_cnt==MAX_BURST-1, a forced split;
  - (c) ~req_valid[g], a withdrawal, which is evaluated even while full=1.
- grant_id holds its value after release until the next grant.
- Bursts therefore have one idle cycle between them; maximum throughput is MAX_BURST/(MAX_BURST+1).
- full=1 in GRANT:
  - No transfer, grant held, beat_cnt frozen.
  - Valid requester data must stay stable; the arbiter does not buffer.
- The FIFO write-pointer logic also gates winc with full. The arbiter never asserts winc while full=1.
- Simultaneous last and forced split in the same beat: single release, same result.
- Requesters that are not granted see ready=0 and must hold their data.
- rst_n asserted mid-burst: immediate return to IDLE with all outputs at reset values. A partially written burst is not rolled back.
- Fairness: a requester continuously valid waits at most 3 bursts of at most MAX_BURST beats plus 3 idle cycles.
- No combinational path from req_data to req_ready.
- The full-to-winc/ready path is combinational.

Test Plan:
- Reset behaviour: reset, then req_valid=4'b0001 single beat, data 0xA5, last=1. Expected:
  - busy rises after 1 cycle.
  - winc=1 for one cycle with wdata=10'h0A5.
  - Then busy=0, grant_id=0.
- Round-robin: all four requesters valid, single-beat last bursts, held. Expected:
  - Grant order 0,1,2,3,0.
  - wdata[9:8] follows that order.
  - One idle cycle between writes.
- Forced split: req 2 valid with last=0 for 10 beats, MAX_BURST=4, req 1 also valid. Expected:
  - Req 2 gets 4 winc pulses.
  - Then req 3 is skipped (not valid) and req 1 gets its burst.
  - Then req 2 resumes.
- Backpressure: full=1 for 3 cycles in the middle of a 3-beat burst. Expected:
  - winc=0 and req_ready=0 during full.
  - beat_cnt is held.
  - The burst completes with exactly 3 writes and no duplicate or lost words.
- Withdrawal: req 1 granted, drops valid after 2 beats. Expected:
  - Release with 2 writes only.
  - The next grant goes to the next valid index after 1.
- Reset mid-burst: assert rst_n=0 asynchronously during beat 2 of 4. Expected:
  - busy=0, winc=0, req_ready=0 immediately.
  - After release of reset, requester 0 has priority again.
